// File: rtl/fetch_mem_unit_if.sv
// Shared memory bus used by fetch_mem_unit.
// The unit is the master: it raises mem_req and holds mem_addr/mem_we/mem_wdata
// stable until the memory answers with a single-cycle mem_ack (plus mem_rdata
// for reads).
interface fetch_mem_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/fetch_mem_unit.sv
// fetch_mem_unit: owns PC, IR and MDR for the multicycle core and runs the
// single shared memory bus handshake.
//
// Access sequence: IDLE (request launched, stall high) -> BUSY (waiting for
// mem_ack or timeout, stall high) -> DONE (stall low for exactly one cycle so
// the controller can advance and commit PC) -> IDLE.
//
// Optional build macro ALIGN_CHECK_EN: when defined, a misaligned access
// address is never put on the bus; the unit skips straight to DONE and sets
// the sticky align_err output (extra port present only in that build).
module fetch_mem_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic             CLK,
  input  logic             CLR,
  // controller strobes
  input  logic             PCWrite,
  input  logic             BranchEq,
  input  logic             BranchNeq,
  input  logic             IorD,
  input  logic             MemWrite,
  input  logic             IRWrite,
  input  logic             PCSrc,
  input  logic             Jen,
  // datapath inputs
  input  logic             Zero,
  input  logic [31:0]      ALUResult,
  input  logic [31:0]      ALUOut,
  input  logic [31:0]      WriteData,
  // memory bus
  fetch_mem_unit_if.master bus,
  // to controller / datapath
  output logic             stall,
  output logic [31:0]      PC,
  output logic [31:0]      Instr,
  output logic [5:0]       Op,
  output logic [5:0]       Funct,
  output logic [31:0]      MDR,
  output logic             bus_err
`ifdef ALIGN_CHECK_EN
  ,
  output logic             align_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    K_FETCH,
    K_READ,
    K_STORE
  } kind_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t             state_q, state_d;
  kind_t              kind_q;
  kind_t              kind_sel;
  logic [CNT_W-1:0]   cnt_q;

  logic               acc;
  logic [31:0]        addr_sel;
  logic               misaligned;
  logic               timeout_hit;

  logic               launch;
  logic               skip;
  logic               finish;
  logic               timed_out;
  logic               capture_ir;
  logic               capture_mdr;

  logic               pcen;
  logic [31:0]        pc_next;

  // Request decode: fetch wins over a data access when both are strobed.
  assign acc      = IRWrite | IorD;
  assign addr_sel = IRWrite ? PC : ALUOut;
  assign kind_sel = IRWrite ? K_FETCH : (MemWrite ? K_STORE : K_READ);

`ifdef ALIGN_CHECK_EN
  assign misaligned = |addr_sel[1:0];
`else
  assign misaligned = 1'b0;
`endif

  // A zero TIMEOUT disables the abort; the counter then simply wraps.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  assign Op    = Instr[31:26];
  assign Funct = Instr[5:0];

  // State register.
  always_ff @(posedge CLK or negedge CLR) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!CLR) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    stall       = 1'b0;
    launch      = 1'b0;
    skip        = 1'b0;
    finish      = 1'b0;
    timed_out   = 1'b0;
    capture_ir  = 1'b0;
    capture_mdr = 1'b0;

    case (state_q)
      S_IDLE: begin
        stall = acc;
        if (acc) begin
          if (misaligned) begin
            skip    = 1'b1;
            state_d = S_DONE;
          end else begin
            launch  = 1'b1;
            state_d = S_BUSY;
          end
        end
      end

      S_BUSY: begin
        stall = 1'b1;
        if (bus.mem_ack) begin
          finish      = 1'b1;
          capture_ir  = (kind_q == K_FETCH);
          capture_mdr = (kind_q == K_READ);
          state_d     = S_DONE;
        end else if (timeout_hit) begin
          finish    = 1'b1;
          timed_out = 1'b1;
          state_d   = S_DONE;
        end
      end

      // One stall-free cycle; never relaunch from here even if acc is held.
      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // Bus request: latch address/direction/data at launch, hold through BUSY.
  always_ff @(posedge CLK or negedge CLR) begin
    // NOTE: the async reset must reach mem_req directly so a reset in the
    // middle of an access withdraws the request without waiting for a clock.
    if (!CLR) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      kind_q        <= K_FETCH;
    end else if (launch) begin
      bus.mem_req   <= 1'b1;
      bus.mem_we    <= MemWrite & IorD & ~IRWrite;
      bus.mem_addr  <= addr_sel;
      bus.mem_wdata <= WriteData;
      kind_q        <= kind_sel;
    end else if (finish) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
    end
  end

  // Wait-state counter: counts BUSY cycles without an answer, clears otherwise.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR)                              cnt_q <= '0;
    else if (state_q == S_BUSY && !finish) cnt_q <= cnt_q + 1'b1;
    else                                   cnt_q <= '0;
  end

  // Instruction and memory data registers capture read data on mem_ack.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      Instr <= '0;
      MDR   <= '0;
    end else begin
      if (capture_ir)  Instr <= bus.mem_rdata;
      if (capture_mdr) MDR   <= bus.mem_rdata;
    end
  end

  // PC update: commits only while the controller is not stalled.
  always_comb begin
    pcen = ~stall & (PCWrite | (BranchEq & Zero) | (BranchNeq & ~Zero));
    if (Jen)        pc_next = {PC[31:28], Instr[25:0], 2'b00};
    else if (PCSrc) pc_next = ALUOut;
    else            pc_next = ALUResult;
  end

  // Program counter register.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR)      PC <= RESET_PC;
    else if (pcen) PC <= pc_next;
  end

  // Sticky error flags; only reset clears them.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR)           bus_err <= 1'b0;
    else if (timed_out) bus_err <= 1'b1;
  end

`ifdef ALIGN_CHECK_EN
  // Sticky misalignment flag.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR)      align_err <= 1'b0;
    else if (skip) align_err <= 1'b1;
  end
`else
  // skip can never rise in this build; keep it referenced for lint.
  logic unused_skip;
  assign unused_skip = skip;
`endif

endmodule
